asyn_fifo_rd_stream: RTL and testbench
======================================

// Module: asyn_fifo_rd_stream
// PURPOSE
// Read-side consumer of the asynchronous FIFO, in the read-clock domain. Pulls
// words via the FIFO read/empty/output_data handshake and re-presents them as a
// valid/ready stream to downstream logic. A 2-entry output buffer with in-flight
// credit tracking sustains 1 word/cycle despite the FIFO's 1-cycle read latency.
// PARAMETERS
// DATA_BITS    10   width of FIFO words and out_data
// CNT_BITS     16   width of delivered-word counter word_count
// PORTS
// r_clk        in   1          read-domain clock; all logic on posedge
// r_reset      in   1          asynchronous, active-high reset
// en           in   1          1 = fetch from FIFO; 0 = stop issuing new reads
// fifo_empty   in   1          FIFO empty flag (read-domain, synchronous to r_clk)
// fifo_rdata   in   DATA_BITS  FIFO output_data; valid 1 cycle after accepted read
// fifo_read    out  1          FIFO read strobe (combinational)
// out_valid    out  1          out_data holds a word
// out_ready    in   1          downstream accepts word when out_valid&out_ready
// out_data     out  DATA_BITS  head word of output buffer
// word_count   out  CNT_BITS   words delivered downstream, saturating
// occupancy    out  2          words held in output buffer, 0..2
// BEHAVIOUR
// - Single clock r_clk; r_reset asynchronous, active-high. During/after reset:
//   fifo_read=0, out_valid=0, out_data=0, word_count=0, occupancy=0, inflight=0.
// - FIFO contract: read sampled at edge N with fifo_empty=0 -> word on
//   fifo_rdata captured by this block at edge N+1. Block never reads when empty.
// - pop   = out_valid & out_ready.
// - fifo_read = en & ~fifo_empty & ((occupancy + inflight - pop) < 2).
// - inflight register: set at edge where fifo_read=1, else cleared (max 1).
// - Edge with inflight=1: fifo_rdata written to buffer tail. Simultaneous
//   push+pop: head advances, new word lands behind any remaining word; order kept.
// - occupancy' = occupancy + inflight - pop; never exceeds 2 (guaranteed by credit).
// - Buffer states: EMPTY(0) -> ONE(push) -> TWO(push); TWO -> ONE(pop);
//   ONE -> EMPTY(pop, no push); ONE stays ONE on push+pop.
// - out_valid = (occupancy != 0); out_data = head entry, stable while
//   out_valid & ~out_ready (no change until popped).
// - Latency: fifo_empty falls before edge N, buffer empty -> read at N,
//   out_valid=1 after N+1. Steady state with out_ready=1: 1 word/cycle.
// - en=0: no new reads; in-flight word still captured; buffer still drains.
// - word_count += 1 on each pop; saturates at 2^CNT_BITS-1, no wrap.
// - fifo_empty rising while inflight=1: in-flight word still captured.
// - Reset mid-operation: buffered and in-flight words discarded; FIFO reset is
//   owned by the FIFO's own reset.
// TESTING
// T1 reset: r_reset=1 with fifo_empty=0, en=1 -> fifo_read=0, out_valid=0,
//    word_count=0; release -> fifo_read=1 next cycle.
// T2 latency: FIFO holds 0x155, out_ready=1 -> fifo_read at N, out_valid=1 and
//    out_data=0x155 after N+1, popped; word_count=1.
// T3 streaming: 64 words 0..63, out_ready=1 -> 1 word/cycle after first, order
//    0..63 preserved, word_count=64, no read while empty.
// T4 backpressure: out_ready=0, 5 words queued -> exactly 2 reads, occupancy=2,
//    fifo_read=0, out_data frozen; out_ready=1 -> remaining 3 delivered in order.
// T5 en gating: deassert en same cycle as a read -> in-flight word delivered,
//    no further reads; reassert en -> fetching resumes, no loss/duplication.
// T6 saturation/reset: CNT_BITS=4, deliver 20 words -> word_count=15;
//    r_reset mid-burst with occupancy=2 -> out_valid=0, occupancy=0 immediately.

Source files
------------

// File: rtl/asyn_fifo_rd_stream_if.sv
// asyn_fifo_rd_stream_if: FIFO read handshake plus downstream valid/ready stream
interface asyn_fifo_rd_stream_if #(parameter int DATA_BITS = 10);
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_read;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_BITS-1:0] out_data;
    modport master (input fifo_empty, fifo_rdata, out_ready, output fifo_read, out_valid, out_data);
    modport slave (output fifo_empty, fifo_rdata, out_ready, input fifo_read, out_valid, out_data);
endinterface

// File: rtl/asyn_fifo_rd_stream.sv
// asyn_fifo_rd_stream: pulls FIFO words into a 2-entry buffer and streams them out
module asyn_fifo_rd_stream #(
    parameter int DATA_BITS = 10,
    parameter int CNT_BITS  = 16
) (
    input  logic                    r_clk,
    input  logic                    r_reset,
    input  logic                    en,
    asyn_fifo_rd_stream_if.master   bus,
    output logic [CNT_BITS-1:0]     word_count,
    output logic [1:0]              occupancy
);
    logic                 inflight;
    logic                 pop;
    logic [1:0]           nxt_occ;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] tail;
    assign pop     = bus.out_valid & bus.out_ready;
    // credit: buffered + in-flight words after this edge must leave room for one more
    assign nxt_occ = occupancy + {1'b0, inflight} - {1'b0, pop};
    assign bus.fifo_read = en & ~r_reset & ~bus.fifo_empty & (nxt_occ < 2'd2);
    assign bus.out_valid = occupancy != 2'd0;
    assign bus.out_data  = head;
    always_ff @(posedge r_clk or posedge r_reset) begin
        if (r_reset) begin
            inflight   <= 1'b0;
            occupancy  <= 2'd0;
            head       <= '0;
            tail       <= '0;
            word_count <= '0;
        end else begin
            inflight  <= bus.fifo_read;
            occupancy <= nxt_occ;
            if (pop && !(&word_count))
                word_count <= word_count + 1'b1;
            if (pop && occupancy == 2'd2)
                head <= tail;
            else if (inflight && (pop || occupancy == 2'd0))
                head <= bus.fifo_rdata;
            if (inflight && (pop ? occupancy == 2'd2 : occupancy == 2'd1))
                tail <= bus.fifo_rdata;
        end
    end
endmodule

// File: tb/tb_asyn_fifo_rd_stream.sv
// tb_asyn_fifo_rd_stream: directed checks against a simple FIFO model and pop log
module tb_asyn_fifo_rd_stream;
    localparam int DB = 10;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic en2 = 1'b0;
    logic [15:0] wc;
    logic [1:0] occ;
    logic [3:0] wc2;
    logic [1:0] occ2;
    int n_chk = 0;
    int n_fail = 0;
    logic [DB-1:0] mem [256];
    logic [DB-1:0] got [256];
    int wp = 0;
    int rp = 0;
    int gcnt = 0;
    int rd_cnt = 0;
    int bad_rd = 0;
    int pops2 = 0;
    always #5 clk = ~clk;
    asyn_fifo_rd_stream_if #(.DATA_BITS(DB)) bus ();
    asyn_fifo_rd_stream_if #(.DATA_BITS(DB)) bus2 ();
    asyn_fifo_rd_stream #(.DATA_BITS(DB), .CNT_BITS(16)) dut (
        .r_clk(clk), .r_reset(rst), .en(en), .bus(bus), .word_count(wc), .occupancy(occ));
    asyn_fifo_rd_stream #(.DATA_BITS(DB), .CNT_BITS(4)) dut_sat (
        .r_clk(clk), .r_reset(rst), .en(en2), .bus(bus2), .word_count(wc2), .occupancy(occ2));
    assign bus.fifo_empty  = (wp == rp);
    assign bus2.fifo_empty = 1'b0;
    assign bus2.fifo_rdata = 10'h2a;
    assign bus2.out_ready  = 1'b1;
    always @(posedge clk) begin
        if (bus.fifo_read) begin
            bus.fifo_rdata <= mem[rp];
            rp <= rp + 1;
            rd_cnt <= rd_cnt + 1;
            if (bus.fifo_empty) bad_rd <= bad_rd + 1;
        end
        if (bus.out_valid && bus.out_ready) begin
            got[gcnt] <= bus.out_data;
            gcnt <= gcnt + 1;
        end
        if (bus2.out_valid) pops2 <= pops2 + 1;
    end
    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask
    task automatic push(input int w);
        mem[wp] = w[DB-1:0];
        wp++;
    endtask
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic check_order(input string tag, input int base, input int first, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (int'(got[base + i]) != first + i) bad++;
        check(tag, bad, 0);
    endtask
    initial begin
        int base;
        int rd0;
        bus.out_ready = 1'b1;
        // T1 reset with a word waiting
        push(10'h155);
        step(1);
        check("t1_read_in_reset", int'(bus.fifo_read), 0);
        check("t1_valid_in_reset", int'(bus.out_valid), 0);
        check("t1_wc_in_reset", int'(wc), 0);
        check("t1_occ_in_reset", int'(occ), 0);
        rst = 1'b0;
        #1;
        check("t1_read_after_release", int'(bus.fifo_read), 1);
        // T2 latency
        step(1);
        check("t2_valid_n", int'(bus.out_valid), 0);
        step(1);
        check("t2_valid_n1", int'(bus.out_valid), 1);
        check("t2_data_n1", int'(bus.out_data), 'h155);
        step(1);
        check("t2_wc", int'(wc), 1);
        check("t2_valid_after_pop", int'(bus.out_valid), 0);
        // T3 streaming 0..63
        base = gcnt;
        for (int i = 0; i < 64; i++) push(i);
        step(65);
        check("t3_count_65", gcnt - base, 63);
        step(1);
        check("t3_count_66", gcnt - base, 64);
        check_order("t3_order", base, 0, 64);
        check("t3_wc", int'(wc), 65);
        // T4 backpressure
        bus.out_ready = 1'b0;
        rd0 = rd_cnt;
        base = gcnt;
        for (int i = 0; i < 5; i++) push(100 + i);
        step(6);
        check("t4_reads", rd_cnt - rd0, 2);
        check("t4_occ", int'(occ), 2);
        check("t4_read_stalled", int'(bus.fifo_read), 0);
        check("t4_head", int'(bus.out_data), 100);
        step(3);
        check("t4_head_frozen", int'(bus.out_data), 100);
        bus.out_ready = 1'b1;
        step(8);
        check("t4_delivered", gcnt - base, 5);
        check_order("t4_order", base, 100, 5);
        check("t4_occ_drained", int'(occ), 0);
        check("t4_wc", int'(wc), 70);
        // T5 en gating with one read in flight
        rd0 = rd_cnt;
        base = gcnt;
        for (int i = 0; i < 3; i++) push(200 + i);
        step(1);
        en = 1'b0;
        step(5);
        check("t5_reads_gated", rd_cnt - rd0, 1);
        check("t5_inflight_delivered", gcnt - base, 1);
        check("t5_read_off", int'(bus.fifo_read), 0);
        en = 1'b1;
        step(6);
        check("t5_delivered", gcnt - base, 3);
        check_order("t5_order", base, 200, 3);
        check("t5_reads_total", rd_cnt - rd0, 3);
        // T6 saturation on the 4-bit counter instance
        en2 = 1'b1;
        step(16);
        check("t6_wc2_pre_sat", int'(wc2), 14);
        step(6);
        check("t6_pops2", pops2, 20);
        check("t6_wc2_sat", int'(wc2), 15);
        en2 = 1'b0;
        // T6 reset with buffer full
        bus.out_ready = 1'b0;
        push(300);
        push(301);
        step(4);
        check("t6_occ_full", int'(occ), 2);
        check("t6_valid_full", int'(bus.out_valid), 1);
        rst = 1'b1;
        #1;
        check("t6_valid_reset", int'(bus.out_valid), 0);
        check("t6_occ_reset", int'(occ), 0);
        check("t6_read_reset", int'(bus.fifo_read), 0);
        check("t6_wc_reset", int'(wc), 0);
        check("no_read_when_empty", bad_rd, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
